// File: rtl/mips_mc_sequencer.sv
// Multi-cycle MIPS control sequencer: steps a shared ALU and unified memory port
// through fetch/decode/execute/memory/writeback with Moore-style control outputs.
module mips_mc_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        zero,
  input  logic        mem_ready,
  input  logic        syscall_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        syscall_req,
  output logic        retire,
  output logic        halted,
  output logic [3:0]  state
);

  localparam logic [3:0] RESET   = 4'd0;
  localparam logic [3:0] FETCH   = 4'd1;
  localparam logic [3:0] DECODE  = 4'd2;
  localparam logic [3:0] EXEC_R  = 4'd3;
  localparam logic [3:0] EXEC_I  = 4'd4;
  localparam logic [3:0] ADDR    = 4'd5;
  localparam logic [3:0] MEM_RD  = 4'd6;
  localparam logic [3:0] MEM_WR  = 4'd7;
  localparam logic [3:0] WB_R    = 4'd8;
  localparam logic [3:0] WB_I    = 4'd9;
  localparam logic [3:0] WB_MEM  = 4'd10;
  localparam logic [3:0] BRANCH  = 4'd11;
  localparam logic [3:0] JUMP    = 4'd12;
  localparam logic [3:0] JREG    = 4'd13;
  localparam logic [3:0] SYSCALL = 4'd14;
  localparam logic [3:0] HALT    = 4'd15;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_NOP     = 6'h00;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2A;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unusedInstBits;
  logic [3:0] decodeTarget;
  logic [3:0] nextState;

  assign opcode         = inst[31:26];
  assign funct          = inst[5:0];
  assign unusedInstBits = ^inst[25:6];

  always_comb begin
    decodeTarget = HALT;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: decodeTarget = EXEC_R;
          FN_NOP:                                decodeTarget = FETCH;
          FN_JR:                                 decodeTarget = JREG;
          FN_SYSCALL:                            decodeTarget = SYSCALL;
          default:                               decodeTarget = HALT;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: decodeTarget = EXEC_I;
      OP_LW, OP_SW:                      decodeTarget = ADDR;
      OP_BEQ, OP_BNE:                    decodeTarget = BRANCH;
      OP_J, OP_JAL:                      decodeTarget = JUMP;
      default:                           decodeTarget = HALT;
    endcase
  end

  always_comb begin
    nextState = state;
    case (state)
      RESET:   nextState = FETCH;
      FETCH:   nextState = mem_ready ? DECODE : FETCH;
      DECODE:  nextState = decodeTarget;
      EXEC_R:  nextState = WB_R;
      EXEC_I:  nextState = WB_I;
      ADDR:    nextState = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:  nextState = mem_ready ? WB_MEM : MEM_RD;
      MEM_WR:  nextState = mem_ready ? FETCH : MEM_WR;
      WB_R, WB_I, WB_MEM, BRANCH, JUMP, JREG: nextState = FETCH;
      SYSCALL: nextState = syscall_ack ? FETCH : SYSCALL;
      HALT:    nextState = HALT;
      default: nextState = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RESET;
    else        state <= nextState;
  end

  // Outputs decode from state alone, except the handshake cycles that also see ready/ack/zero.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 3'b000;
    reg_write   = 1'b0;
    reg_dst     = 2'b00;
    mem_to_reg  = 2'b00;
    syscall_req = 1'b0;
    retire      = 1'b0;
    halted      = 1'b0;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 3'b010;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = 3'b010;
        retire    = (decodeTarget == FETCH);
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        case (funct)
          FN_SUB:  alu_op = 3'b110;
          FN_AND:  alu_op = 3'b000;
          FN_OR:   alu_op = 3'b001;
          FN_SLT:  alu_op = 3'b111;
          default: alu_op = 3'b010;
        endcase
      end
      WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
        retire    = 1'b1;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OP_ORI:  alu_op = 3'b001;
          OP_LUI:  alu_op = 3'b011;
          default: alu_op = 3'b010;
        endcase
      end
      WB_I: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b010;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        retire  = mem_ready;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        retire     = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b110;
        pc_src    = 2'b01;
        retire    = 1'b1;
        pc_write  = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        retire   = 1'b1;
        if (opcode == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
      end
      JREG: begin
        pc_write = 1'b1;
        pc_src   = 2'b11;
        retire   = 1'b1;
      end
      SYSCALL: begin
        syscall_req = 1'b1;
        retire      = syscall_ack;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

endmodule
